// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-lane data memory.
// Covers access-size codes, the controller state type, lane enables and alignment faults.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  // Byte lanes touched by an access of the given size starting at byte offset off.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << off;
  endfunction

  function automatic logic size_fault(input logic [1:0] size, input logic [2:0] off,
                                      input logic has_dword);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = off[0];
      SZ_WORD: f = |off[1:0];
      default: f = !has_dword || (|off);
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bus between the memory stage and the byte-lane data memory.
interface dmem_bytelane_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_lane.sv
// One byte-wide synchronous RAM bank; the data memory stacks one bank per byte lane.
module dmem_lane #(
  parameter int DEPTH = 4096,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory: sub-word stores/loads, alignment faults, fixed-latency responses,
// and a post-reset zero-fill sweep.
// state    | meaning
// ST_CLEAR | sweeping words 0..DEPTH-1 with zeros, requests blocked
// ST_IDLE  | accepting one request per cycle
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 4096,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic          clock,
  input logic          reset_n,
  dmem_bytelane_if.slave bus
);
  localparam int NLANE  = DATA_W / 8;
  localparam int OFF_W  = $clog2(NLANE);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ADDR_W = IDX_W + OFF_W;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt;
  logic               clr_we;
  logic               accept, fault;
  logic [2:0]         off;
  logic [IDX_W-1:0]   idx;
  logic [NLANE-1:0]   lane_en;
  logic [DATA_W-1:0]  wdata_rep, rd_word;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign accept        = bus.req_valid & bus.req_ready;
  assign off           = 3'(bus.req_addr[OFF_W-1:0]);
  assign idx           = bus.req_addr[ADDR_W-1:OFF_W];
  assign fault         = size_fault(bus.req_size, off, DATA_W == 64);
  assign lane_en       = NLANE'(lane_mask(bus.req_size, off));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt <= clr_we ? clr_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we = 1'b1;
          if (clr_cnt == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Store data is replicated so every lane already sees its own byte of the value.
  always_comb begin
    wdata_rep = bus.req_wdata;
    case (bus.req_size)
      SZ_BYTE: wdata_rep = {NLANE{bus.req_wdata[7:0]}};
      SZ_HALF: wdata_rep = {(NLANE/2){bus.req_wdata[15:0]}};
      SZ_WORD: wdata_rep = {(NLANE/4){bus.req_wdata[31:0]}};
      default: wdata_rep = bus.req_wdata;
    endcase
  end

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    dmem_lane #(.DEPTH(DEPTH)) u_lane (
      .clock (clock),
      .we    (clr_we | (accept & bus.req_we & ~fault & lane_en[i])),
      .addr  (clr_we ? clr_cnt : idx),
      .wdata (clr_we ? 8'h00 : wdata_rep[8*i +: 8]),
      .rdata (rd_word[8*i +: 8])
    );
  end

  logic             s1_valid, s1_we, s1_fault, s1_unsigned;
  logic [1:0]       s1_size;
  logic [OFF_W-1:0] s1_off;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_we       <= 1'b0;
      s1_fault    <= 1'b0;
      s1_unsigned <= 1'b0;
      s1_size     <= SZ_BYTE;
      s1_off      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_we       <= bus.req_we;
        s1_fault    <= fault;
        s1_unsigned <= bus.req_unsigned;
        s1_size     <= bus.req_size;
        s1_off      <= bus.req_addr[OFF_W-1:0];
      end
    end
  end

  logic [DATA_W-1:0] shifted, keep, ext, res1;
  logic              sign;

  always_comb begin
    shifted = rd_word >> {s1_off, 3'b000};
    keep    = '1;
    sign    = 1'b0;
    case (s1_size)
      SZ_BYTE: begin keep = DATA_W'(8'hff);         sign = shifted[7];  end
      SZ_HALF: begin keep = DATA_W'(16'hffff);      sign = shifted[15]; end
      SZ_WORD: begin keep = DATA_W'(32'hffff_ffff); sign = shifted[31]; end
      default: begin keep = '1;                     sign = shifted[DATA_W-1]; end
    endcase
    ext = shifted & keep;
    if (!s1_unsigned && sign) ext = ext | ~keep;
    res1 = (s1_valid && !s1_we && !s1_fault) ? ext : '0;
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_valid, s2_fault;
    logic [DATA_W-1:0] s2_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid <= 1'b0;
        s2_fault <= 1'b0;
        s2_rdata <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_fault <= s1_fault;
          s2_rdata <= res1;
        end
      end
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_fault = s2_fault;
    assign bus.rsp_rdata = s2_rdata;
  end else begin : g_lat1
    assign bus.rsp_valid = s1_valid;
    assign bus.rsp_fault = s1_fault;
    assign bus.rsp_rdata = res1;
  end
endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: READ_LAT=1 and READ_LAT=2 instances driven in lockstep and
// compared against a byte-array reference memory.
module tb_dmem_bytelane;
  import dmem_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4096;
  localparam int AW    = 14;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } rsp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic          rq_valid = 1'b0, rq_we = 1'b0, rq_uns = 1'b0;
  logic [1:0]    rq_size = 2'b00;
  logic [AW-1:0] rq_addr = '0;
  logic [31:0]   rq_wdata = '0;
  logic [7:0]    mdl [0:16383];
  rsp_t          exp_q[$];
  rsp_t          rx1[$];
  rsp_t          rx2[$];

  dmem_bytelane_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  dmem_bytelane_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

  assign if1.req_valid = rq_valid;    assign if2.req_valid = rq_valid;
  assign if1.req_we = rq_we;          assign if2.req_we = rq_we;
  assign if1.req_size = rq_size;      assign if2.req_size = rq_size;
  assign if1.req_unsigned = rq_uns;   assign if2.req_unsigned = rq_uns;
  assign if1.req_addr = rq_addr;      assign if2.req_addr = rq_addr;
  assign if1.req_wdata = rq_wdata;    assign if2.req_wdata = rq_wdata;

  dmem_bytelane #(.DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(if1));
  dmem_bytelane #(.DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(if2));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (if1.rsp_valid === 1'b1) rx1.push_back({if1.rsp_rdata, if1.rsp_fault, cyc});
    if (if2.rsp_valid === 1'b1) rx2.push_back({if2.rsp_rdata, if2.rsp_fault, cyc});
  end

  task automatic model_clear();
    foreach (mdl[i]) mdl[i] = 8'h00;
  endtask

  // Issue one request (caller guarantees req_ready) and record the reference response.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wd);
    rsp_t   e;
    int     n;
    longint v;
    rq_valid = 1'b1; rq_we = we; rq_size = sz; rq_uns = uns; rq_addr = addr; rq_wdata = wd;
    @(posedge clock); #1;
    rq_valid = 1'b0;
    n = 1 << sz;
    e.cyc = cyc; e.fault = 1'b0; e.rdata = '0;
    if (sz == 2'd3 || (int'(addr) % n) != 0) begin
      e.fault = 1'b1;
    end else if (we) begin
      for (int i = 0; i < n; i++) mdl[int'(addr) + i] = 8'(wd >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(mdl[int'(addr) + i]) << (8 * i));
      if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      e.rdata = 32'(v);
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int k = 0;
    while ((rx1.size() < n || rx2.size() < n) && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    repeat (3) @(posedge clock);
    #1;
    ok = (rx1.size() == n) && (rx2.size() == n);
  endtask

  task automatic release_and_count(output int n);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (n < 6000) begin
      @(posedge clock); #1;
      n++;
      if (if1.req_ready === 1'b1 && if2.req_ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    int   n;
    bit   ok;
    rsp_t e, r;
    reset_n = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (if1.req_ready !== 1'b0 || if2.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b/%b want 0", if1.req_ready, if2.req_ready);
    end
    checks++;
    if (if1.rsp_valid !== 1'b0 || if2.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b/%b want 0", if1.rsp_valid, if2.rsp_valid);
    end
    checks++;
    if (if1.rsp_rdata !== 32'h0 || if2.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rsp_rdata: got %h/%h want 0", if1.rsp_rdata, if2.rsp_rdata);
    end
    checks++;
    if (if1.rsp_fault !== 1'b0 || if2.rsp_fault !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_fault: got %b/%b want 0", if1.rsp_fault, if2.rsp_fault);
    end
    release_and_count(n);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL reset_clear_cycles: got %0d want %0d", n, DEPTH);
    end
    do_req(1'b0, SZ_WORD, 1'b0, 14'h0000, 32'h0);
    do_req(1'b0, SZ_WORD, 1'b0, 14'h3ffc, 32'h0);
    wait_rx(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL reset_load_count: got %0d/%0d want 2", rx1.size(), rx2.size());
    end else for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        if (k == 0) r = rx1.pop_front(); else r = rx2.pop_front();
        checks++;
        if (r.rdata !== 32'h0 || r.fault !== 1'b0) begin
          errors++; $display("FAIL reset_load[%0d] lat%0d: got %h/%b want 00000000/0", i, k + 1, r.rdata, r.fault);
        end
        checks++;
        if (r.cyc - e.cyc + 1 != k + 1) begin
          errors++; $display("FAIL reset_load_latency[%0d]: got %0d want %0d", i, r.cyc - e.cyc + 1, k + 1);
        end
      end
    end
    exp_q.delete(); rx1.delete(); rx2.delete();
  endtask

  task automatic test_basic();
    logic [31:0] want [6];
    bit          ok;
    rsp_t        e, r;
    want = '{32'h0, 32'h0, 32'hdead7fef, 32'hffffffde, 32'h000000de, 32'hffffdead};
    do_req(1'b1, SZ_WORD, 1'b0, 14'h010, 32'hdeadbeef);
    do_req(1'b1, SZ_BYTE, 1'b0, 14'h011, 32'h0000007f);
    do_req(1'b0, SZ_WORD, 1'b0, 14'h010, 32'h0);
    do_req(1'b0, SZ_BYTE, 1'b0, 14'h013, 32'h0);
    do_req(1'b0, SZ_BYTE, 1'b1, 14'h013, 32'h0);
    do_req(1'b0, SZ_HALF, 1'b0, 14'h012, 32'h0);
    wait_rx(6, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_count: got %0d/%0d want 6", rx1.size(), rx2.size());
    end else for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        if (k == 0) r = rx1.pop_front(); else r = rx2.pop_front();
        checks++;
        if (r.rdata !== want[i] || r.fault !== 1'b0) begin
          errors++; $display("FAIL basic_rsp[%0d] lat%0d: got %h/%b want %h/0", i, k + 1, r.rdata, r.fault, want[i]);
        end
        checks++;
        if (r.cyc - e.cyc + 1 != k + 1) begin
          errors++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, r.cyc - e.cyc + 1, k + 1);
        end
      end
    end
    exp_q.delete(); rx1.delete(); rx2.delete();
  endtask

  task automatic test_fault();
    bit   ok;
    rsp_t e, r;
    do_req(1'b1, SZ_WORD,  1'b0, 14'h020, 32'ha5a55a5a);
    do_req(1'b1, SZ_HALF,  1'b0, 14'h021, 32'h0000ffff);
    do_req(1'b0, SZ_WORD,  1'b0, 14'h020, 32'h0);
    do_req(1'b0, SZ_DWORD, 1'b0, 14'h020, 32'h0);
    do_req(1'b0, SZ_WORD,  1'b0, 14'h022, 32'h0);
    do_req(1'b1, SZ_WORD,  1'b0, 14'h026, 32'h11223344);
    do_req(1'b0, SZ_WORD,  1'b1, 14'h024, 32'h0);
    do_req(1'b0, SZ_HALF,  1'b1, 14'h023, 32'h0);
    wait_rx(8, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL fault_count: got %0d/%0d want 8", rx1.size(), rx2.size());
    end else for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        if (k == 0) r = rx1.pop_front(); else r = rx2.pop_front();
        checks++;
        if (r.rdata !== e.rdata || r.fault !== e.fault) begin
          errors++; $display("FAIL fault_rsp[%0d] lat%0d: got %h/%b want %h/%b", i, k + 1, r.rdata, r.fault, e.rdata, e.fault);
        end
        checks++;
        if (r.cyc - e.cyc + 1 != k + 1) begin
          errors++; $display("FAIL fault_latency[%0d]: got %0d want %0d", i, r.cyc - e.cyc + 1, k + 1);
        end
      end
    end
    exp_q.delete(); rx1.delete(); rx2.delete();
  endtask

  task automatic test_back_to_back();
    bit         ok;
    rsp_t       e, r;
    logic [1:0] sz;
    int         o;
    do_req(1'b1, SZ_WORD, 1'b0, 14'h040, 32'h12345678);
    do_req(1'b0, SZ_WORD, 1'b0, 14'h040, 32'h0);
    for (int i = 0; i < 8; i++) begin
      sz = 2'($urandom_range(0, 2));
      o  = $urandom_range(0, 15);
      o  = (o / (1 << sz)) * (1 << sz);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), AW'(14'h040 + o), $urandom());
    end
    wait_rx(10, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_count: got %0d/%0d want 10", rx1.size(), rx2.size());
    end else for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        if (k == 0) r = rx1.pop_front(); else r = rx2.pop_front();
        checks++;
        if (r.rdata !== e.rdata || r.fault !== e.fault) begin
          errors++; $display("FAIL b2b_rsp[%0d] lat%0d: got %h/%b want %h/%b", i, k + 1, r.rdata, r.fault, e.rdata, e.fault);
        end
        checks++;
        if (r.cyc - e.cyc + 1 != k + 1) begin
          errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, r.cyc - e.cyc + 1, k + 1);
        end
      end
    end
    exp_q.delete(); rx1.delete(); rx2.delete();
  endtask

  task automatic test_random();
    bit            ok;
    rsp_t          e, r;
    logic [1:0]    sz;
    int            a;
    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 127);
      if ($urandom_range(0, 3) != 0) a = (a / (1 << sz)) * (1 << sz);
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 16383) / 8) * 8;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), AW'(a), $urandom());
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clock); #1;
      end
    end
    wait_rx(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL random_count: got %0d/%0d want 200", rx1.size(), rx2.size());
    end else for (int i = 0; i < 200; i++) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        if (k == 0) r = rx1.pop_front(); else r = rx2.pop_front();
        checks++;
        if (r.rdata !== e.rdata || r.fault !== e.fault) begin
          errors++; $display("FAIL random_rsp[%0d] lat%0d: got %h/%b want %h/%b", i, k + 1, r.rdata, r.fault, e.rdata, e.fault);
        end
        checks++;
        if (r.cyc - e.cyc + 1 != k + 1) begin
          errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, r.cyc - e.cyc + 1, k + 1);
        end
      end
    end
    exp_q.delete(); rx1.delete(); rx2.delete();
  endtask

  task automatic test_reset_midflight();
    int   n;
    bit   ok;
    rsp_t e, r;
    do_req(1'b1, SZ_WORD, 1'b0, 14'h0000, 32'h11111111);
    do_req(1'b1, SZ_WORD, 1'b0, 14'h3ffc, 32'h22222222);
    do_req(1'b1, SZ_WORD, 1'b0, 14'h0040, 32'h33333333);
    wait_rx(3, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midflight_setup_count: got %0d/%0d want 3", rx1.size(), rx2.size());
    end
    exp_q.delete(); rx1.delete(); rx2.delete();
    do_req(1'b0, SZ_WORD, 1'b0, 14'h0040, 32'h0);
    do_req(1'b0, SZ_WORD, 1'b0, 14'h0044, 32'h0);
    reset_n = 1'b0;
    exp_q.delete(); rx1.delete(); rx2.delete();
    model_clear();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    checks++;
    if (if1.req_ready !== 1'b0 || if2.req_ready !== 1'b0) begin
      errors++; $display("FAIL midclear_ready: got %b/%b want 0", if1.req_ready, if2.req_ready);
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    release_and_count(n);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL midclear_restart_cycles: got %0d want %0d", n, DEPTH);
    end
    checks++;
    if (rx1.size() != 0 || rx2.size() != 0) begin
      errors++; $display("FAIL dropped_rsp: got %0d/%0d responses want 0", rx1.size(), rx2.size());
    end
    rx1.delete(); rx2.delete();
    do_req(1'b0, SZ_WORD, 1'b0, 14'h0000, 32'h0);
    do_req(1'b0, SZ_WORD, 1'b0, 14'h3ffc, 32'h0);
    do_req(1'b0, SZ_WORD, 1'b0, 14'h0040, 32'h0);
    wait_rx(3, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midflight_load_count: got %0d/%0d want 3", rx1.size(), rx2.size());
    end else for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        if (k == 0) r = rx1.pop_front(); else r = rx2.pop_front();
        checks++;
        if (r.rdata !== e.rdata || r.fault !== e.fault) begin
          errors++; $display("FAIL midflight_load[%0d] lat%0d: got %h/%b want %h/%b", i, k + 1, r.rdata, r.fault, e.rdata, e.fault);
        end
        checks++;
        if (r.cyc - e.cyc + 1 != k + 1) begin
          errors++; $display("FAIL midflight_latency[%0d]: got %0d want %0d", i, r.cyc - e.cyc + 1, k + 1);
        end
      end
    end
    exp_q.delete(); rx1.delete(); rx2.delete();
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_fault();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
